// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined 19x18 multiplier between NUM_REQ requesters.
// A tag pipeline follows each product so it can be returned with its requester id.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*19-1:0]  req_a,
    input  logic [NUM_REQ*18-1:0]  req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [18:0]            res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   mul_ce,
    output logic [18:0]            mul_din0,
    output logic [17:0]            mul_din1,
    input  logic [18:0]            mul_dout,
    output logic                   busy
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [ID_W-1:0]    id_q [MUL_LAT];
    logic [ID_W-1:0]    id_d [MUL_LAT];

    logic               stall;
    logic               grantAny;
    logic [ID_W-1:0]    grantIdx;

    // A held result freezes the multiplier and the tags together, so they stay aligned.
    assign res_valid = vld_q[MUL_LAT-1];
    assign res_id    = id_q[MUL_LAT-1];
    assign res_data  = mul_dout;
    assign stall     = res_valid & ~res_ready;
    assign mul_ce    = ~stall;
    assign busy      = |vld_q;

    // Scan starts just after the last winner, so the most recent winner has lowest priority.
    always_comb begin
        int cand;
        cand     = 0;
        grantAny = 1'b0;
        grantIdx = '0;
        if (!stall) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = (int'(ptr_q) + k) % NUM_REQ;
                if (!grantAny && req_valid[cand]) begin
                    grantAny = 1'b1;
                    grantIdx = cand[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        if (grantAny) begin
            req_ready[grantIdx] = 1'b1;
            mul_din0            = req_a[grantIdx*19 +: 19];
            mul_din1            = req_b[grantIdx*18 +: 18];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        vld_d = vld_q;
        id_d  = id_q;
        if (grantAny) begin
            ptr_d = grantIdx;
        end
        if (mul_ce) begin
            vld_d[0] = grantAny;
            id_d[0]  = grantIdx;
            for (int s = 1; s < MUL_LAT; s++) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
            vld_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural 3-stage multiplier.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mul_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  reqValid;
    logic [3:0]  reqReady;
    logic [75:0] reqA;
    logic [71:0] reqB;
    logic        resValid;
    logic        resReady;
    logic [18:0] resData;
    logic [1:0]  resId;
    logic        mulCe;
    logic [18:0] mulDin0;
    logic [17:0] mulDin1;
    logic [18:0] mulDout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mul_share_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady),
        .req_a(reqA), .req_b(reqB),
        .res_valid(resValid), .res_ready(resReady),
        .res_data(resData), .res_id(resId),
        .mul_ce(mulCe), .mul_din0(mulDin0), .mul_din1(mulDin1),
        .mul_dout(mulDout), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the shared multiplier: unsigned multiply, low 19 bits, 3 ce stages.
    logic [18:0] mulPipe [3];
    logic [36:0] mulFull;
    assign mulFull = {18'b0, mulDin0} * {19'b0, mulDin1};
    assign mulDout = mulPipe[2];
    always @(posedge clk) begin
        if (mulCe) begin
            mulPipe[0] <= mulFull[18:0];
            mulPipe[1] <= mulPipe[0];
            mulPipe[2] <= mulPipe[1];
        end
    end

    function automatic logic [18:0] refMul(input logic [18:0] a, input logic [17:0] b);
        logic signed [37:0] p;
        p = $signed(a) * $signed({1'b0, b});
        return p[18:0];
    endfunction

    task automatic setOp(input int idx, input logic [18:0] a, input logic [17:0] b);
        reqA[idx*19 +: 19] = a;
        reqB[idx*18 +: 18] = b;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset    = 1'b0;
        reqValid = '0;
        resReady = 1'b1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        reqValid = '0;
        resReady = 1'b1;
        reqA     = '0;
        reqB     = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (resValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got=%0b exp=0", resValid); end
        checks++; if (reqReady !== 4'b0) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", reqReady); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (mulCe !== 1'b1) begin errors++; $display("[TB] FAIL reset_mul_ce got=%0b exp=1", mulCe); end
        checks++; if (mulDin0 !== 19'h0) begin errors++; $display("[TB] FAIL reset_din0 got=%h exp=0", mulDin0); end
        checks++; if (mulDin1 !== 18'h0) begin errors++; $display("[TB] FAIL reset_din1 got=%h exp=0", mulDin1); end
        checks++; if (resId !== 2'd0) begin errors++; $display("[TB] FAIL reset_res_id got=%0d exp=0", resId); end
        reset = 1'b1;
    endtask

    task automatic test_single_op();
        @(negedge clk);
        setOp(0, 19'h7FFFD, 18'd5);
        reqValid = 4'b0001;
        #1;
        checks++; if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant got=%b exp=0001", reqReady); end
        checks++; if (mulDin0 !== 19'h7FFFD) begin errors++; $display("[TB] FAIL single_din0 got=%h exp=7fffd", mulDin0); end
        checks++; if (mulDin1 !== 18'd5) begin errors++; $display("[TB] FAIL single_din1 got=%h exp=5", mulDin1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_c0 got=%0b exp=0", busy); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            reqValid = '0;
            #1;
            checks++; if (resValid !== (k == 3)) begin errors++; $display("[TB] FAIL single_res_valid_c%0d got=%0b exp=%0b", k, resValid, (k == 3)); end
            checks++; if (busy !== (k <= 3)) begin errors++; $display("[TB] FAIL single_busy_c%0d got=%0b exp=%0b", k, busy, (k <= 3)); end
            if (k == 3) begin
                checks++; if (resData !== 19'h7FFF1) begin errors++; $display("[TB] FAIL single_data got=%h exp=7fff1", resData); end
                checks++; if (resId !== 2'd0) begin errors++; $display("[TB] FAIL single_id got=%0d exp=0", resId); end
            end
        end
    endtask

    task automatic test_truncation();
        @(negedge clk);
        setOp(0, 19'h3FFFF, 18'd2);
        reqValid = 4'b0001;
        #1;
        checks++; if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL trunc_grant0 got=%b exp=0001", reqReady); end
        @(negedge clk);
        setOp(0, 19'h40000, 18'h3FFFF);
        #1;
        checks++; if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL trunc_grant1 got=%b exp=0001", reqReady); end
        @(negedge clk);
        reqValid = '0;
        @(negedge clk);
        #1;
        checks++; if (resValid !== 1'b1 || resData !== 19'h7FFFE) begin errors++; $display("[TB] FAIL trunc_pos got=%0b/%h exp=1/7fffe", resValid, resData); end
        @(negedge clk);
        #1;
        checks++; if (resValid !== 1'b1 || resData !== 19'h40000) begin errors++; $display("[TB] FAIL trunc_neg got=%0b/%h exp=1/40000", resValid, resData); end
        checks++; if (resData !== refMul(19'h40000, 18'h3FFFF)) begin errors++; $display("[TB] FAIL trunc_ref got=%h exp=%h", resData, refMul(19'h40000, 18'h3FFFF)); end
        @(negedge clk);
        #1;
        checks++; if (resValid !== 1'b0) begin errors++; $display("[TB] FAIL trunc_drain got=%0b exp=0", resValid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] expId;
        pulseReset();
        for (int i = 0; i < 4; i++) setOp(i, 19'(i + 1), 18'd3);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            reqValid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                checks++; if (reqReady !== (4'b0001 << (c % 4))) begin errors++; $display("[TB] FAIL rr_grant_c%0d got=%b exp=%b", c, reqReady, 4'b0001 << (c % 4)); end
            end
            if (c >= 3 && c < 11) begin
                expId = 2'((c - 3) % 4);
                checks++; if (resValid !== 1'b1 || resId !== expId) begin errors++; $display("[TB] FAIL rr_res_c%0d got=%0b/%0d exp=1/%0d", c, resValid, resId, expId); end
                checks++; if (resData !== 19'(3 * (int'(expId) + 1))) begin errors++; $display("[TB] FAIL rr_data_c%0d got=%h exp=%h", c, resData, 19'(3 * (int'(expId) + 1))); end
            end
            if (c == 11) begin
                checks++; if (resValid !== 1'b0) begin errors++; $display("[TB] FAIL rr_drain got=%0b exp=0", resValid); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  ids  [6];
        logic [18:0] opA  [6];
        logic [17:0] opB  [6];
        logic [18:0] expD [6];
        logic [18:0] heldData;
        logic [1:0]  heldId;
        logic        inStall;
        int k;
        int rx;
        ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        opA  = '{19'd7, 19'h7FFFF, 19'd1000, 19'h7FFFE, 19'd12, 19'd0};
        opB  = '{18'd6, 18'd100, 18'd1000, 18'd3, 18'd12, 18'h3FFFF};
        expD = '{19'h0002A, 19'h7FF9C, 19'h74240, 19'h7FFFA, 19'h00090, 19'h00000};
        k = 0;
        rx = 0;
        heldData = '0;
        heldId = '0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            inStall  = (c >= 4 && c <= 8);
            resReady = ~inStall;
            if (k < 6) begin
                setOp(int'(ids[k]), opA[k], opB[k]);
                reqValid = 4'b0001 << ids[k];
            end else begin
                reqValid = '0;
            end
            #1;
            checks++; if (mulCe !== ~inStall) begin errors++; $display("[TB] FAIL bp_ce_c%0d got=%0b exp=%0b", c, mulCe, ~inStall); end
            if (inStall) begin
                checks++; if (reqReady !== 4'b0) begin errors++; $display("[TB] FAIL bp_ready_c%0d got=%b exp=0000", c, reqReady); end
                if (c == 4) begin
                    heldData = resData;
                    heldId   = resId;
                end else begin
                    checks++; if (resValid !== 1'b1 || resData !== heldData || resId !== heldId) begin errors++; $display("[TB] FAIL bp_hold_c%0d got=%0b/%h/%0d exp=1/%h/%0d", c, resValid, resData, resId, heldData, heldId); end
                end
            end else if (k < 6) begin
                checks++; if (reqReady !== reqValid) begin errors++; $display("[TB] FAIL bp_grant_c%0d got=%b exp=%b", c, reqReady, reqValid); end
                if (reqReady == reqValid) k++;
            end
            if (resValid && resReady) begin
                checks++;
                if (rx >= 6) begin
                    errors++; $display("[TB] FAIL bp_extra_c%0d got=%h exp=none", c, resData);
                end else if (resData !== expD[rx] || resId !== ids[rx]) begin
                    errors++; $display("[TB] FAIL bp_result%0d got=%h/%0d exp=%h/%0d", rx, resData, resId, expD[rx], ids[rx]);
                end
                rx++;
            end
        end
        checks++; if (rx != 6 || k != 6) begin errors++; $display("[TB] FAIL bp_count got=%0d/%0d exp=6/6", rx, k); end
    endtask

    task automatic test_fairness();
        logic [3:0] vIn  [7];
        logic [3:0] vExp [7];
        vIn  = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1110, 4'b1110};
        vExp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        pulseReset();
        for (int i = 0; i < 4; i++) setOp(i, 19'd0, 18'd0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            reqValid = vIn[c];
            #1;
            checks++; if (reqReady !== vExp[c]) begin errors++; $display("[TB] FAIL fair_grant_c%0d got=%b exp=%b", c, reqReady, vExp[c]); end
        end
        @(negedge clk);
        reqValid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        pulseReset();
        setOp(0, 19'd1, 18'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reqValid = 4'b0001;
            #1;
            checks++; if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL mid_grant_c%0d got=%b exp=0001", c, reqReady); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before got=%0b exp=1", busy); end
        @(negedge clk);
        reqValid = '0;
        reset    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (resValid !== 1'b0 || busy !== 1'b0 || resId !== 2'd0) begin errors++; $display("[TB] FAIL mid_after_reset got=%0b/%0b/%0d exp=0/0/0", resValid, busy, resId); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (resValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale_c%0d got=%0b/%0b exp=0/0", c, resValid, busy); end
        end
        @(negedge clk);
        reqValid = 4'hF;
        #1;
        checks++; if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL mid_ptr got=%b exp=0001", reqReady); end
        @(negedge clk);
        reqValid = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_truncation();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 19-bit-signed × 18-bit-unsigned pipelined multiplier (product truncated to 19 bits, 3 ce-enabled register stages) between NUM_REQ requesters in the sort datapath.
- Accepts operand pairs over per-requester valid/ready, drives the multiplier's ce/din0/din1, and tracks each issued operation in a tag pipeline.
- Returns each product with its requester id on a single valid/ready result port. Result backpressure stalls the multiplier via ce.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of res_id; must equal clog2(NUM_REQ).
- MUL_LAT, 3, ce-enabled clock edges from operands on mul_din* to product on mul_dout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*19  signed operand A, requester i at bits [19i+18:19i].
- req_b  in  NUM_REQ*18  unsigned operand B, requester i at bits [18i+17:18i].
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  19  product (low 19 bits, signed).
- res_id  out  ID_W  requester index of res_data.
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  19  multiplier operand A.
- mul_din1  out  18  multiplier operand B.
- mul_dout  in  19  multiplier product.
- busy  out  1  high while any op is in flight.

Behaviour:
- Reset (reset=0 at a rising edge):
  - Tag pipeline valid bits cleared; RR pointer set to NUM_REQ-1, so requester 0 has top priority.
  - Outputs after reset: res_valid=0, req_ready=0, busy=0, mul_ce=1, mul_din0=0, mul_din1=0, res_id=0.
  - Reset asserted mid-operation discards all in-flight ops; no result emerges from them afterwards.
- Stall: stall = res_valid & ~res_ready. mul_ce = ~stall. While stalled:
  - No grant; req_ready=0.
  - Tag pipeline and multiplier hold.
  - res_data, res_id and res_valid hold stable.
- Arbitration (combinational, each cycle with ~stall):
  - Scan from pointer+1 upward, wrapping modulo NUM_REQ; the first i with req_valid[i]=1 is granted.
  - req_ready[i]=1 for the granted requester only.
  - mul_din0/mul_din1 are muxed from the granted requester; they are 0 when there is no grant.
  - On grant, the pointer updates to i at the clock edge. With no grant, the pointer holds.
  - At most one issue per cycle. Sustained throughput is 1 op/cycle.
- A transfer occurs when req_valid[i] & req_ready[i]. Requesters must hold operands stable until accepted. req_ready never depends on res_ready except through stall.
- Tag pipeline: MUL_LAT stages of {vld, id}, advancing only when mul_ce=1.
  - Stage 0 loads {grant_any, grant_idx}.
  - The last stage drives res_valid and res_id.
  - res_data = mul_dout (pass-through, aligned with the last stage).
- Latency: an op accepted in cycle t (mul_ce=1) produces res_valid in cycle t+MUL_LAT, if there are no stalls. Each stall cycle adds one cycle.
- Ordering: results are returned in issue order. No reordering, no drops, no duplicates.
- Arithmetic: res_data = (signed A × zero-extended B) mod 2^19, interpreted as signed. The block itself does no arithmetic.
- busy = OR of all tag-pipeline vld bits.
- Simultaneous events:
  - A grant in the same cycle as a result handshake is allowed.
  - If the result is stalled while requesters are valid, none are granted.
  - A requester that drops req_valid before grant loses its slot; there is no penalty and the pointer is unaffected.

Test Plan:
- Single op: after reset, requester 0 issues a=-3 (0x7FFFD), b=5, res_ready=1 → res_valid exactly 3 cycles later with res_data=0x7FFF1 (-15), res_id=0; busy high for 3 cycles.
- Truncation: a=0x3FFFF, b=2 → res_data=0x7FFFE (-2); a=0x40000 (-262144), b=0x3FFFF → res_data = low 19 bits of the product, checked against a reference model.
- Round robin: all 4 requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3, one per cycle; res_id follows the same order with 3-cycle offset.
- Backpressure: stream of 6 ops, res_ready=0 for 5 cycles mid-stream →
  - mul_ce=0 and req_ready=0 throughout the stall;
  - res_data/res_id stable;
  - after release, all 6 results delivered in order with none lost.
- Fairness/skip: only requesters 1 and 3 valid, pointer at 1 → grants 3,1,3,1; requester 2 raising valid after pointer=1 is granted before 3.
- Reset mid-flight: 3 ops in flight, assert reset for 1 cycle → res_valid=0, busy=0, pointer=NUM_REQ-1; no stale results appear in the next 5 cycles.
